// File: rtl/booth_seq_mul_if.sv
// Operand/product handshake bundle for booth_seq_mul. The block owns the slave modport;
// the operand source / result consumer side uses master.
`timescale 1ns/1ps
interface booth_seq_mul_if #(
    parameter int WIDTH = 8
);
    // Both sides: a transfer happens on a rising edge where valid && ready are both 1;
    // a source holds valid and its payload steady until that edge.
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               a_signed;
    logic               b_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;
    logic [1:0]         dbg_state;

    modport slave (
        input  in_valid, a, b, a_signed, b_signed, out_ready,
        output in_ready, out_valid, p, busy, dbg_state
    );

    modport master (
        output in_valid, a, b, a_signed, b_signed, out_ready,
        input  in_ready, out_valid, p, busy, dbg_state
    );
endinterface

// File: rtl/booth_seq_mul.sv
// Multi-cycle radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, per-operand signedness.
// Operands are widened by one bit so one signed Booth pass covers all four sign modes.
`timescale 1ns/1ps
module booth_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    booth_seq_mul_if.slave    bus
);
    localparam int EW = WIDTH + 1;
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [AW-1:0]      r_acc;
    logic [EW-1:0]      r_q;
    logic [EW-1:0]      r_m;
    logic               r_qm1;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic               w_accept;
    logic               w_step;
    logic               w_last;

    logic [EW-1:0]      w_a_ext;
    logic [EW-1:0]      w_b_ext;
    logic [AW-1:0]      w_m_sx;
    logic [AW-1:0]      w_sum;
    logic [AW-1:0]      w_acc_nxt;
    logic [EW-1:0]      w_q_nxt;
    logic               w_qm1_nxt;
    logic [AW+EW-1:0]   w_prod;

    // Unsigned operands get a zero top bit so the signed Booth recoding sees them as positive.
    assign w_a_ext = {bus.a_signed & bus.a[WIDTH-1], bus.a};
    assign w_b_ext = {bus.b_signed & bus.b[WIDTH-1], bus.b};
    assign w_m_sx  = {r_m[EW-1], r_m};

    always_comb begin
        w_sum = r_acc;
        unique case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_m_sx;
            2'b10:   w_sum = r_acc - w_m_sx;
            default: w_sum = r_acc;
        endcase
    end

    // Arithmetic right shift of {A, Q, q_m1} by one position.
    assign w_acc_nxt = {w_sum[AW-1], w_sum[AW-1:1]};
    assign w_q_nxt   = {w_sum[0], r_q[EW-1:1]};
    assign w_qm1_nxt = r_q[0];
    assign w_prod    = {w_acc_nxt, w_q_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
            r_q   <= w_b_ext;
            r_m   <= w_a_ext;
            r_qm1 <= 1'b0;
            r_cnt <= CNT_LOAD;
        end else if (w_step) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_qm1 <= w_qm1_nxt;
            r_cnt <= r_cnt - CNT_LAST;
            // The widened product is exact; its low 2*WIDTH bits are the result in every sign mode.
            if (w_last) begin
                r_p <= w_prod[2*WIDTH-1:0];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.p         = r_p;
    assign bus.dbg_state = r_state;

    a_done_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == S_DONE && !bus.out_ready) |=> (r_state == S_DONE && $stable(r_p)));

    a_busy_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == S_BUSY) |-> (r_cnt != '0));
endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul: directed Booth corner cases, backpressure, async abort and a random sweep,
// with products checked against an integer-multiply reference through expected queues.
`timescale 1ns/1ps
module tb_booth_seq_mul;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   accept_cyc;
  logic [15:0] exp_q[$];
  logic [31:0] exp16_q[$];

  booth_seq_mul_if #(.WIDTH(8))  if8();
  booth_seq_mul_if #(.WIDTH(16)) if16();

  booth_seq_mul #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  booth_seq_mul #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                       input logic as, input logic bs);
    longint x;
    longint y;
    x = as ? longint'($signed(a)) : longint'({56'd0, a});
    y = bs ? longint'($signed(b)) : longint'({56'd0, b});
    return 16'(x * y);
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic as, input logic bs);
    longint x;
    longint y;
    x = as ? longint'($signed(a)) : longint'({48'd0, a});
    y = bs ? longint'($signed(b)) : longint'({48'd0, b});
    return 32'(x * y);
  endfunction

  // ---------------- scoreboard monitors ----------------
  task automatic monitor8();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && if8.out_valid === 1'b1 && if8.out_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL product8_unexpected: p=%h delivered, none expected", if8.p);
        end else begin
          e = exp_q.pop_front();
          if (if8.p !== e) begin
            n_fail++;
            $display("FAIL product8: p=%h expected %h", if8.p, e);
          end
        end
      end
    end
  endtask

  task automatic monitor16();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && if16.out_valid === 1'b1 && if16.out_ready === 1'b1) begin
        n_cmp++;
        if (exp16_q.size() == 0) begin
          n_fail++;
          $display("FAIL product16_unexpected: p=%h delivered, none expected", if16.p);
        end else begin
          e = exp16_q.pop_front();
          if (if16.p !== e) begin
            n_fail++;
            $display("FAIL product16: p=%h expected %h", if16.p, e);
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled on falling edges.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                        input logic as, input logic bs, input bit push);
    int n;
    @(posedge clk); #1;
    if8.in_valid = 1'b1;
    if8.a        = a;
    if8.b        = b;
    if8.a_signed = as;
    if8.b_signed = bs;
    n = 0;
    @(negedge clk);
    while (if8.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (if8.in_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept8_timeout: in_ready=%b expected 1", if8.in_ready);
    end else if (push) begin
      exp_q.push_back(ref8(a, b, as, bs));
    end
    @(posedge clk); #1;
    accept_cyc   = cyc;
    if8.in_valid = 1'b0;
    if8.a        = 8'($urandom);
    if8.b        = 8'($urandom);
    if8.a_signed = 1'($urandom_range(0, 1));
    if8.b_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid8(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (if8.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - accept_cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b expected 1 0 0",
               if8.in_ready, if8.out_valid, if8.busy);
    end
    n_cmp++;
    if (if8.p !== 16'h0 || if16.p !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_p: p8=%h p16=%h expected 0 0", if8.p, if16.p);
    end
    n_cmp++;
    if (if8.dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d expected 0", if8.dbg_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (if8.in_ready !== 1'b1 || if16.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready8=%b in_ready16=%b expected 1 1",
               if8.in_ready, if16.in_ready);
    end
  endtask

  task automatic test_latency();
    int nb;
    int n;
    int lat;
    drive8(8'h80, 8'h7F, 1'b1, 1'b1, 1'b1);
    nb = 0;
    n  = 0;
    @(negedge clk);
    while (if8.out_valid !== 1'b1 && n < 200) begin
      if (if8.busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    lat = cyc - accept_cyc;
    n_cmp++;
    if (lat != 9) begin
      n_fail++;
      $display("FAIL latency: out_valid after %0d edges, expected 9", lat);
    end
    n_cmp++;
    if (nb != 9) begin
      n_fail++;
      $display("FAIL busy_cycles: busy high %0d cycles, expected 9", nb);
    end
    n_cmp++;
    if (if8.p !== 16'hC080) begin
      n_fail++;
      $display("FAIL neg128_x_127: p=%h expected c080", if8.p);
    end
  endtask

  task automatic test_back_to_back();
    int a1;
    int lat;
    drive8(8'd255, 8'd255, 1'b0, 1'b0, 1'b1);
    a1 = accept_cyc;
    drive8(8'h80, 8'h80, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (accept_cyc - a1 != 11) begin
      n_fail++;
      $display("FAIL b2b_spacing: accepts %0d edges apart, expected 11", accept_cyc - a1);
    end
    wait_valid8(lat);
    n_cmp++;
    if (if8.p !== 16'h4000 || lat != 9) begin
      n_fail++;
      $display("FAIL neg128_sq: p=%h lat=%0d expected 4000 9", if8.p, lat);
    end
  endtask

  task automatic test_mixed_sign();
    int lat;
    drive8(8'd200, 8'hFD, 1'b0, 1'b1, 1'b1);
    wait_valid8(lat);
    n_cmp++;
    if (if8.p !== 16'hFDA8) begin
      n_fail++;
      $display("FAIL u200_x_sneg3: p=%h expected fda8", if8.p);
    end
    drive8(8'hFD, 8'd200, 1'b1, 1'b0, 1'b1);
    wait_valid8(lat);
    n_cmp++;
    if (if8.p !== 16'hFDA8) begin
      n_fail++;
      $display("FAIL sneg3_x_u200: p=%h expected fda8", if8.p);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int raise_cyc;
    int bad;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    drive8(8'd100, 8'hF9, 1'b1, 1'b1, 1'b1);
    wait_valid8(lat);
    @(posedge clk); #1;
    if8.in_valid = 1'b1;
    if8.a        = 8'd5;
    if8.b        = 8'd6;
    if8.a_signed = 1'b0;
    if8.b_signed = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0 || if8.busy !== 1'b0 ||
          if8.p !== 16'hFD44) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d unstable cycles (p=%h ov=%b ir=%b) expected 0, p fd44",
               bad, if8.p, if8.out_valid, if8.in_ready);
    end
    @(posedge clk); #1;
    if8.out_ready = 1'b1;
    raise_cyc     = cyc;
    drive8(8'd5, 8'd6, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (accept_cyc - raise_cyc != 2) begin
      n_fail++;
      $display("FAIL backpressure_accept: accepted %0d edges after out_ready, expected 2",
               accept_cyc - raise_cyc);
    end
    wait_valid8(lat);
    n_cmp++;
    if (if8.p !== 16'd30 || lat != 9) begin
      n_fail++;
      $display("FAIL held_operand: p=%h lat=%0d expected 001e 9", if8.p, lat);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    int seen;
    drive8(8'd50, 8'd60, 1'b1, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.busy !== 1'b0 ||
        if8.p !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: ir=%b ov=%b busy=%b p=%h expected 1 0 0 0000",
               if8.in_ready, if8.out_valid, if8.busy, if8.p);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (if8.out_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_output: out_valid high %0d cycles, expected 0", seen);
    end
    drive8(8'd7, 8'hFA, 1'b1, 1'b1, 1'b1);
    wait_valid8(lat);
    n_cmp++;
    if (if8.p !== 16'hFFD6 || lat != 9) begin
      n_fail++;
      $display("FAIL post_reset_7x_neg6: p=%h lat=%0d expected ffd6 9", if8.p, lat);
    end
  endtask

  task automatic test_width16();
    int n;
    int acc16;
    int lat;
    @(posedge clk); #1;
    if16.in_valid = 1'b1;
    if16.a        = 16'h8000;
    if16.b        = 16'h8000;
    if16.a_signed = 1'b1;
    if16.b_signed = 1'b1;
    n = 0;
    @(negedge clk);
    while (if16.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    exp16_q.push_back(ref16(16'h8000, 16'h8000, 1'b1, 1'b1));
    @(posedge clk); #1;
    acc16         = cyc;
    if16.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (if16.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - acc16;
    n_cmp++;
    if (if16.p !== 32'h4000_0000 || lat != 17) begin
      n_fail++;
      $display("FAIL w16_neg32768_sq: p=%h lat=%0d expected 40000000 17", if16.p, lat);
    end
  endtask

  task automatic test_random_sweep();
    int lat;
    int stall;
    int bad_lat;
    logic [7:0] a;
    logic [7:0] b;
    bad_lat = 0;
    for (int i = 0; i < 300; i++) begin
      a     = 8'($urandom);
      b     = 8'($urandom);
      stall = $urandom_range(0, 3);
      @(posedge clk); #1;
      if8.out_ready = (stall == 0);
      drive8(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      wait_valid8(lat);
      if (lat != 9) bad_lat++;
      if (stall != 0) begin
        repeat (stall) @(posedge clk);
        #1;
        if8.out_ready = 1'b1;
      end
    end
    n_cmp++;
    if (bad_lat != 0) begin
      n_fail++;
      $display("FAIL sweep_latency: %0d transactions off 9-edge latency, expected 0", bad_lat);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst_n          = 1'b1;
    if8.in_valid   = 1'b0;
    if8.a          = '0;
    if8.b          = '0;
    if8.a_signed   = 1'b0;
    if8.b_signed   = 1'b0;
    if8.out_ready  = 1'b1;
    if16.in_valid  = 1'b0;
    if16.a         = '0;
    if16.b         = '0;
    if16.a_signed  = 1'b0;
    if16.b_signed  = 1'b0;
    if16.out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    fork
      monitor8();
      monitor16();
    join_none
    test_reset();
    test_latency();
    test_back_to_back();
    test_mixed_sign();
    test_backpressure();
    test_async_reset();
    test_width16();
    test_random_sweep();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || exp16_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d products outstanding, expected 0/0",
               exp_q.size(), exp16_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
